// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner codes and the latched request header.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StResp  = 2'd3
   } arb_state_e;

   typedef enum logic {
      OwnCpu = 1'b0,
      OwnDbg = 1'b1
   } owner_e;

   // Fields that must outlive ISSUE: who owns the access and whether it returns data.
   typedef struct packed {
      owner_e owner;
      logic   we;
   } req_hdr_t;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select for the data-memory arbiter.
// DMEM_ARB_RR_EN selects round-robin; otherwise CPU priority with a starvation guard.
`ifdef DMEM_ARB_RR_EN
module dmem_arb_pick
   import dmem_arb_pkg::*;
(
   input  logic   cpu_req_i,
   input  logic   dbg_req_i,
   input  owner_e rr_last_i,
   output owner_e winner_o
);

   always_comb begin
      winner_o = OwnCpu;
      if (cpu_req_i && dbg_req_i) begin
         winner_o = (rr_last_i == OwnCpu) ? OwnDbg : OwnCpu;
      end else if (dbg_req_i) begin
         winner_o = OwnDbg;
      end
   end

endmodule
`else
module dmem_arb_pick
   import dmem_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned CNT_W      = cnt_width(STARVE_MAX)
) (
   input  logic             cpu_req_i,
   input  logic             dbg_req_i,
   input  logic [CNT_W-1:0] starve_cnt_i,
   output owner_e           winner_o
);

   logic starved;

   assign starved = (STARVE_MAX != 0) && (starve_cnt_i == CNT_W'(STARVE_MAX));

   always_comb begin
      winner_o = OwnCpu;
      if (cpu_req_i && dbg_req_i) begin
         winner_o = starved ? OwnDbg : OwnCpu;
      end else if (dbg_req_i) begin
         winner_o = OwnDbg;
      end
   end

endmodule
`endif

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between CPU and debug ports: IDLE -> ISSUE -> WAIT -> RESP.
// Define DMEM_ARB_RR_EN for round-robin arbitration instead of CPU priority with starvation guard.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned AW         = 8,
   parameter int unsigned DW         = 32,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_gnt,
   output logic          dbg_rvalid,
   output logic [DW-1:0] dbg_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int unsigned       WAIT_W    = cnt_width(MEM_LAT);
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_LAT - 1);

   arb_state_e        state_q, state_d;
   req_hdr_t          hdr_q, hdr_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              cpu_gnt_q, cpu_gnt_d;
   logic              cpu_rvalid_q, cpu_rvalid_d;
   logic [DW-1:0]     cpu_rdata_q, cpu_rdata_d;
   logic              dbg_gnt_q, dbg_gnt_d;
   logic              dbg_rvalid_q, dbg_rvalid_d;
   logic [DW-1:0]     dbg_rdata_q, dbg_rdata_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [AW-1:0]     mem_addr_q, mem_addr_d;
   logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
   logic [DW-1:0]     rdata_cap;
   owner_e            winner;

`ifdef DMEM_ARB_RR_EN
   owner_e rr_last_q, rr_last_d;

   dmem_arb_pick u_pick (
      .cpu_req_i (cpu_req),
      .dbg_req_i (dbg_req),
      .rr_last_i (rr_last_q),
      .winner_o  (winner)
   );
`else
   localparam int unsigned      CNT_W      = cnt_width(STARVE_MAX);
   localparam logic [CNT_W-1:0] STARVE_CAP = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

   dmem_arb_pick #(
      .STARVE_MAX (STARVE_MAX),
      .CNT_W      (CNT_W)
   ) u_pick (
      .cpu_req_i    (cpu_req),
      .dbg_req_i    (dbg_req),
      .starve_cnt_i (starve_cnt_q),
      .winner_o     (winner)
   );
`endif

   always_comb begin
      state_d      = state_q;
      hdr_d        = hdr_q;
      wait_cnt_d   = wait_cnt_q;
      cpu_gnt_d    = 1'b0;
      cpu_rvalid_d = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      dbg_gnt_d    = 1'b0;
      dbg_rvalid_d = 1'b0;
      dbg_rdata_d  = dbg_rdata_q;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = '0;
      mem_wdata_d  = '0;
      rdata_cap    = hdr_q.we ? '0 : mem_rdata;
`ifdef DMEM_ARB_RR_EN
      rr_last_d    = rr_last_q;
`else
      starve_cnt_d = starve_cnt_q;
`endif

      // Outputs are registered, so each state's outputs are loaded on the edge entering it.
      case (state_q)
         StIdle: begin
            if (cpu_req || dbg_req) begin
               hdr_d.owner = winner;
               hdr_d.we    = (winner == OwnDbg) ? dbg_we : cpu_we;
               mem_en_d    = 1'b1;
               mem_we_d    = hdr_d.we;
               mem_addr_d  = (winner == OwnDbg) ? dbg_addr : cpu_addr;
               mem_wdata_d = (winner == OwnDbg) ? dbg_wdata : cpu_wdata;
               cpu_gnt_d   = (winner == OwnCpu);
               dbg_gnt_d   = (winner == OwnDbg);
`ifdef DMEM_ARB_RR_EN
               rr_last_d   = winner;
`else
               if ((winner == OwnDbg) || !dbg_req) begin
                  starve_cnt_d = '0;
               end else if (starve_cnt_q != STARVE_CAP) begin
                  starve_cnt_d = starve_cnt_q + 1'b1;
               end
`endif
               state_d = StIssue;
            end
         end
         StIssue: begin
            wait_cnt_d = WAIT_INIT;
            state_d    = StWait;
         end
         StWait: begin
            if (wait_cnt_q == '0) begin
               if (hdr_q.owner == OwnDbg) begin
                  dbg_rvalid_d = 1'b1;
                  dbg_rdata_d  = rdata_cap;
               end else begin
                  cpu_rvalid_d = 1'b1;
                  cpu_rdata_d  = rdata_cap;
               end
               state_d = StResp;
            end else begin
               wait_cnt_d = wait_cnt_q - 1'b1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         hdr_q        <= '{owner: OwnCpu, we: 1'b0};
         wait_cnt_q   <= '0;
         cpu_gnt_q    <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         cpu_rdata_q  <= '0;
         dbg_gnt_q    <= 1'b0;
         dbg_rvalid_q <= 1'b0;
         dbg_rdata_q  <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
`ifdef DMEM_ARB_RR_EN
         rr_last_q    <= OwnCpu;
`else
         starve_cnt_q <= '0;
`endif
      end else begin
         state_q      <= state_d;
         hdr_q        <= hdr_d;
         wait_cnt_q   <= wait_cnt_d;
         cpu_gnt_q    <= cpu_gnt_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dbg_gnt_q    <= dbg_gnt_d;
         dbg_rvalid_q <= dbg_rvalid_d;
         dbg_rdata_q  <= dbg_rdata_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
`ifdef DMEM_ARB_RR_EN
         rr_last_q    <= rr_last_d;
`else
         starve_cnt_q <= starve_cnt_d;
`endif
      end
   end

   assign cpu_gnt    = cpu_gnt_q;
   assign cpu_rvalid = cpu_rvalid_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign cpu_stall  = cpu_req & ~cpu_rvalid_q;
   assign dbg_gnt    = dbg_gnt_q;
   assign dbg_rvalid = dbg_rvalid_q;
   assign dbg_rdata  = dbg_rdata_q;
   assign mem_en     = mem_en_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

endmodule
